// File: rtl/crypto8_top.sv
// crypto8_top: 8-bit symmetric byte cipher with a one-cycle registered output.
// Encrypt: out = rotl(p ^ k, k[2:0]) + k.  Decrypt: out = rotr(c - k, k[2:0]) ^ k.
// Build option: define CRYPTO_ROT_EN to include the rotate stage. When it is
// undefined, the rotate stage is bypassed (b = a), which is still invertible.
module crypto8_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic [7:0] inp,
  input  logic [7:0] key,
  input  logic       in_valid,
  output logic [7:0] out,
  output logic       out_valid
);

  logic [7:0] w_enc_a;
  logic [7:0] w_enc_b;
  logic [7:0] w_enc;
  logic [7:0] w_dec_b;
  logic [7:0] w_dec_a;
  logic [7:0] w_dec;
  logic [7:0] w_result;

  logic [7:0] r_out;
  logic       r_out_valid;

  // Encrypt path, first stage: whiten with the key.
  assign w_enc_a = inp ^ key;

  // Decrypt path, first stage: undo the final key addition (borrow discarded).
  assign w_dec_b = inp - key;

`ifdef CRYPTO_ROT_EN
  logic [2:0]  w_rot;
  logic [15:0] w_enc_dbl;
  logic [15:0] w_dec_dbl;

  assign w_rot = key[2:0];

  // Rotate by shifting a doubled copy; the wanted byte is the upper half
  // for a left rotate and the lower half for a right rotate.
  assign w_enc_dbl = {w_enc_a, w_enc_a} << w_rot;
  assign w_dec_dbl = {w_dec_b, w_dec_b} >> w_rot;
  assign w_enc_b   = w_enc_dbl[15:8];
  assign w_dec_a   = w_dec_dbl[7:0];
`else
  assign w_enc_b = w_enc_a;
  assign w_dec_a = w_dec_b;
`endif

  // Final stages: key addition on encrypt, key XOR on decrypt.
  assign w_enc    = w_enc_b + key;
  assign w_dec    = w_dec_a ^ key;
  assign w_result = sel ? w_enc : w_dec;

  // Output register: reset wins over in_valid; without a valid input the
  // byte holds and the valid flag drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_result;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_crypto8_top.sv
// tb_crypto8_top: directed test-plan vectors, round-trip sweeps and a
// randomized run of crypto8_top, checked against an arithmetic reference model.
// Honours CRYPTO_ROT_EN the same way the design does.
module tb_crypto8_top;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic [7:0] inp;
  logic [7:0] key;
  logic       in_valid;
  logic [7:0] out;
  logic       out_valid;

  int n_total;
  int n_pass;

  // Model state: what out/out_valid must show after the latest edge.
  logic [7:0] exp_out;
  logic       exp_v;

  crypto8_top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .inp       (inp),
    .key       (key),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate left by one bit position using plain arithmetic.
  function automatic int rotl1(input int a);
    return ((a * 2) % 256) + (a / 128);
  endfunction

  // Rotate right by one bit position using plain arithmetic.
  function automatic int rotr1(input int a);
    return (a / 2) + ((a % 2) * 128);
  endfunction

  function automatic logic [7:0] model_enc(input int p, input int k);
    int a;
    a = p ^ k;
`ifdef CRYPTO_ROT_EN
    for (int i = 0; i < (k % 8); i++) a = rotl1(a);
`endif
    return 8'((a + k) % 256);
  endfunction

  function automatic logic [7:0] model_dec(input int c, input int k);
    int b;
    b = (c - k + 256) % 256;
`ifdef CRYPTO_ROT_EN
    for (int i = 0; i < (k % 8); i++) b = rotr1(b);
`endif
    return 8'(b ^ k);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, expv);
  endtask

  // One clock: drive at the falling edge, update the model, sample 1ns after
  // the rising edge and compare both outputs against the model.
  task automatic step(input logic r, input logic v, input logic s,
                      input logic [7:0] i, input logic [7:0] k);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    sel      = s;
    inp      = i;
    key      = k;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_out = 8'h00;
      exp_v   = 1'b0;
    end else if (v) begin
      exp_out = s ? model_enc(i, k) : model_dec(i, k);
      exp_v   = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    check("model_out", out, exp_out);
    check("model_valid", {7'd0, out_valid}, {7'd0, exp_v});
  endtask

  logic [7:0] ct;
  logic [7:0] kk;
  logic [7:0] exp_7e;
  logic [7:0] exp_80;

  initial begin
    n_total  = 0;
    n_pass   = 0;
    exp_out  = 8'h00;
    exp_v    = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 1'b0;
    inp      = 8'h00;
    key      = 8'h00;
`ifdef CRYPTO_ROT_EN
    exp_7e = 8'h60;
    exp_80 = 8'h04;
`else
    exp_7e = 8'h7E;
    exp_80 = 8'h82;
`endif

    // Reset held with in_valid high: outputs stay cleared.
    step(1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C);
    step(1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C);
    check("reset_out", out, 8'h00);
    check("reset_valid", {7'd0, out_valid}, 8'h00);

    // Key 0x3C pairs.
    step(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C);
    check("enc_a5", out, 8'hD5);
    check("enc_a5_valid", {7'd0, out_valid}, 8'h01);
    step(1'b1, 1'b1, 1'b0, 8'hD5, 8'h3C);
    check("dec_d5", out, 8'hA5);
    step(1'b1, 1'b1, 1'b1, 8'h7E, 8'h3C);
    check("enc_7e", out, exp_7e);
    step(1'b1, 1'b1, 1'b0, exp_7e, 8'h3C);
    check("dec_7e", out, 8'h7E);

    // Rotate / wrap edge cases.
    step(1'b1, 1'b1, 1'b1, 8'h80, 8'h01);
    check("enc_80_k01", out, exp_80);
    step(1'b1, 1'b1, 1'b0, exp_80, 8'h01);
    check("dec_k01", out, 8'h80);
    step(1'b1, 1'b1, 1'b1, 8'h00, 8'hFF);
    check("enc_00_kff", out, 8'hFE);
    step(1'b1, 1'b1, 1'b0, 8'hFE, 8'hFF);
    check("dec_fe_kff", out, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h5A, 8'h00);
    check("enc_identity", out, 8'h5A);
    step(1'b1, 1'b1, 1'b0, 8'hC3, 8'h00);
    check("dec_identity", out, 8'hC3);

    // in_valid low for three cycles: value holds, valid drops.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
      check("hold_out", out, 8'hC3);
      check("hold_valid", {7'd0, out_valid}, 8'h00);
    end

    // Mid-stream reset discards the in-flight byte.
    step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22);
    check("midreset_out", out, 8'h00);

    // Back-to-back alternating sel: encrypt, then decrypt the ciphertext.
    for (int i = 0; i < 64; i++) begin
      kk = 8'($urandom);
      ct = model_enc(i * 4 + 1, kk);
      step(1'b1, 1'b1, 1'b1, 8'(i * 4 + 1), kk);
      step(1'b1, 1'b1, 1'b0, ct, kk);
      check("b2b_roundtrip", out, 8'(i * 4 + 1));
    end

    // Round-trip sweep: every plaintext under keys covering all rotations,
    // plus random keys, feeding the observed ciphertext back in.
    for (int j = 0; j < 12; j++) begin
      kk = (j < 8) ? 8'((j * 37 + 8) % 256) : 8'($urandom);
      for (int p = 0; p < 256; p++) begin
        step(1'b1, 1'b1, 1'b1, 8'(p), kk);
        ct = out;
        step(1'b1, 1'b1, 1'b0, ct, kk);
        check("sweep_roundtrip", out, 8'(p));
      end
    end

    // Fully random traffic including idle cycles and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
